// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared types and constants for the instruction/data memory port arbiter.
//   arb_state_e : arbiter FSM states
//   grant_e     : which requester owns (or last owned) the shared port
//   RESP_*      : AXI response codes, passed through unmodified by the arbiter
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_ADDR = 3'd3,
      WR_RESP = 3'd4
   } arb_state_e;

   typedef enum logic {
      GRANT_DM = 1'b0,
      GRANT_IM = 1'b1
   } grant_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one AXI-lite memory slave between the instruction-fetch master (im_*,
// read only) and the data master (dm_*, read/write). One transaction at a time,
// round-robin between the two sides; on the data side a write beats a read.
//
// Ports:
//   clk, rstn                    clock, synchronous active-low reset
//   dm_ar*/dm_r*                 data-side read address / read response
//   dm_aw*/dm_w*/dm_b*           data-side write address / data / response
//   im_ar*/im_r*                 fetch-side read address / read response
//   mem_ar*/mem_r*               shared read channels toward memory
//   mem_aw*/mem_w*/mem_b*        shared write channels toward memory
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDRLEN = 8,
   parameter int DATALEN = 32,
   parameter int STRBLEN = DATALEN / 8
) (
   input  logic               clk,
   input  logic               rstn,
   // data read
   input  logic               dm_arvalid,
   input  logic [ADDRLEN-1:0] dm_araddr,
   output logic               dm_arready,
   output logic               dm_rvalid,
   output logic [DATALEN-1:0] dm_rdata,
   output logic [1:0]         dm_rresp,
   input  logic               dm_rready,
   // data write
   input  logic               dm_awvalid,
   input  logic [ADDRLEN-1:0] dm_awaddr,
   output logic               dm_awready,
   input  logic               dm_wvalid,
   input  logic [DATALEN-1:0] dm_wdata,
   input  logic [STRBLEN-1:0] dm_wstrb,
   output logic               dm_wready,
   output logic               dm_bvalid,
   output logic [1:0]         dm_bresp,
   input  logic               dm_bready,
   // instruction read
   input  logic               im_arvalid,
   input  logic [ADDRLEN-1:0] im_araddr,
   output logic               im_arready,
   output logic               im_rvalid,
   output logic [DATALEN-1:0] im_rdata,
   output logic [1:0]         im_rresp,
   input  logic               im_rready,
   // shared memory port
   output logic               mem_arvalid,
   output logic [ADDRLEN-1:0] mem_araddr,
   input  logic               mem_arready,
   input  logic               mem_rvalid,
   input  logic [DATALEN-1:0] mem_rdata,
   input  logic [1:0]         mem_rresp,
   output logic               mem_rready,
   output logic               mem_awvalid,
   output logic [ADDRLEN-1:0] mem_awaddr,
   input  logic               mem_awready,
   output logic               mem_wvalid,
   output logic [DATALEN-1:0] mem_wdata,
   output logic [STRBLEN-1:0] mem_wstrb,
   input  logic               mem_wready,
   input  logic               mem_bvalid,
   input  logic [1:0]         mem_bresp,
   output logic               mem_bready
);

   arb_state_e         state_q, state_d;
   grant_e             last_grant_q, last_grant_d;
   logic [ADDRLEN-1:0] addr_q, addr_d;
   logic [DATALEN-1:0] wdata_q, wdata_d;
   logic [STRBLEN-1:0] wstrb_q, wstrb_d;
   logic               mem_arvalid_q, mem_arvalid_d;
   logic               mem_awvalid_q, mem_awvalid_d;
   logic               mem_wvalid_q, mem_wvalid_d;

   logic dm_wr_req, dm_req, im_req, pick_dm;
   logic aw_done, w_done;
   logic in_rd_data, in_wr_resp, gnt_dm;

   // A data write needs both address and data present to count as a request.
   assign dm_wr_req = dm_awvalid & dm_wvalid;
   assign dm_req    = dm_wr_req | dm_arvalid;
   assign im_req    = im_arvalid;
   // Data side wins when alone, or on a tie when instruction had the last grant.
   assign pick_dm   = dm_req & (~im_req | (last_grant_q == GRANT_IM));

   // last_grant_q doubles as the owner of the transaction in flight.
   assign in_rd_data = (state_q == RD_DATA);
   assign in_wr_resp = (state_q == WR_RESP);
   assign gnt_dm     = (last_grant_q == GRANT_DM);

   // Response channels are routed combinationally; only the owner sees valid.
   assign mem_rready = in_rd_data & (gnt_dm ? dm_rready : im_rready);
   assign dm_rvalid  = in_rd_data & gnt_dm & mem_rvalid;
   assign im_rvalid  = in_rd_data & ~gnt_dm & mem_rvalid;
   assign dm_rdata   = mem_rdata;
   assign im_rdata   = mem_rdata;
   assign dm_rresp   = mem_rresp;
   assign im_rresp   = mem_rresp;
   assign dm_bvalid  = in_wr_resp & mem_bvalid;
   assign dm_bresp   = mem_bresp;
   assign mem_bready = in_wr_resp & dm_bready;

   assign mem_arvalid = mem_arvalid_q;
   assign mem_awvalid = mem_awvalid_q;
   assign mem_wvalid  = mem_wvalid_q;
   assign mem_araddr  = addr_q;
   assign mem_awaddr  = addr_q;
   assign mem_wdata   = wdata_q;
   assign mem_wstrb   = wstrb_q;

   // A write channel counts as done if it already handshook or does so now.
   assign aw_done = ~mem_awvalid_q | mem_awready;
   assign w_done  = ~mem_wvalid_q | mem_wready;

   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      mem_arvalid_d = mem_arvalid_q;
      mem_awvalid_d = mem_awvalid_q;
      mem_wvalid_d  = mem_wvalid_q;
      dm_arready    = 1'b0;
      dm_awready    = 1'b0;
      dm_wready     = 1'b0;
      im_arready    = 1'b0;
      case (state_q)
         IDLE: begin
            // Readies are held low while in reset so nothing is accepted.
            if (rstn) begin
               if (pick_dm) begin
                  last_grant_d = GRANT_DM;
                  if (dm_wr_req) begin
                     dm_awready    = 1'b1;
                     dm_wready     = 1'b1;
                     addr_d        = dm_awaddr;
                     wdata_d       = dm_wdata;
                     wstrb_d       = dm_wstrb;
                     mem_awvalid_d = 1'b1;
                     mem_wvalid_d  = 1'b1;
                     state_d       = WR_ADDR;
                  end else begin
                     dm_arready    = 1'b1;
                     addr_d        = dm_araddr;
                     mem_arvalid_d = 1'b1;
                     state_d       = RD_ADDR;
                  end
               end else if (im_req) begin
                  last_grant_d  = GRANT_IM;
                  im_arready    = 1'b1;
                  addr_d        = im_araddr;
                  mem_arvalid_d = 1'b1;
                  state_d       = RD_ADDR;
               end
            end
         end
         RD_ADDR: begin
            if (mem_arready) begin
               mem_arvalid_d = 1'b0;
               state_d       = RD_DATA;
            end
         end
         RD_DATA: begin
            if (mem_rvalid && mem_rready) state_d = IDLE;
         end
         WR_ADDR: begin
            if (mem_awvalid_q && mem_awready) mem_awvalid_d = 1'b0;
            if (mem_wvalid_q && mem_wready)   mem_wvalid_d  = 1'b0;
            if (aw_done && w_done)            state_d       = WR_RESP;
         end
         WR_RESP: begin
            if (mem_bvalid && mem_bready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q       <= IDLE;
         last_grant_q  <= GRANT_IM;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         mem_arvalid_q <= 1'b0;
         mem_awvalid_q <= 1'b0;
         mem_wvalid_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         mem_arvalid_q <= mem_arvalid_d;
         mem_awvalid_q <= mem_awvalid_d;
         mem_wvalid_q  <= mem_wvalid_d;
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one AXI-lite memory slave between the core's instruction-fetch master and its data-memory master, so both can use a single unified memory. Requests are served one at a time, with round-robin arbitration between the two requesters. The instruction side is read-only; the data side issues reads and writes. The block sits between the Core's `im`/`dm` master ports and the memory model or bus.

## Interface
Parameters:
- ADDRLEN, 8: address width on all ports.
- DATALEN, 32: data width.
- STRBLEN, DATALEN/8: write-strobe width.

Ports (name direction width meaning):
- clk  in  1  clock
- rstn  in  1  synchronous, active-low reset
- dm_arvalid in 1, dm_araddr in ADDRLEN, dm_arready out 1: data read address.
- dm_rvalid out 1, dm_rdata out DATALEN, dm_rresp out 2, dm_rready in 1: data read response.
- dm_awvalid in 1, dm_awaddr in ADDRLEN, dm_awready out 1: data write address.
- dm_wvalid in 1, dm_wdata in DATALEN, dm_wstrb in STRBLEN, dm_wready out 1: data write data.
- dm_bvalid out 1, dm_bresp out 2, dm_bready in 1: data write response.
- im_arvalid in 1, im_araddr in ADDRLEN, im_arready out 1: fetch read address.
- im_rvalid out 1, im_rdata out DATALEN, im_rresp out 2, im_rready in 1: fetch read response.
- mem_arvalid out 1, mem_araddr out ADDRLEN, mem_arready in 1: shared read address.
- mem_rvalid in 1, mem_rdata in DATALEN, mem_rresp in 2, mem_rready out 1: shared read response.
- mem_awvalid out 1, mem_awaddr out ADDRLEN, mem_awready in 1: shared write address.
- mem_wvalid out 1, mem_wdata out DATALEN, mem_wstrb out STRBLEN, mem_wready in 1: shared write data.
- mem_bvalid in 1, mem_bresp in 2, mem_bready out 1: shared write response.

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP. At most one transaction is outstanding on `mem_*`.
- Request types:
  - DW (data write): `dm_awvalid & dm_wvalid` both high.
  - DR (data read): `dm_arvalid`.
  - IR (instruction read): `im_arvalid`.
- A data-side request is DW if present, otherwise DR. Write takes precedence over read so stores retire first.
- Arbitration in IDLE, between the data side and the instruction side:
  - If only one side requests, it wins.
  - If both request, the side not granted last wins.
  - `last_grant` is 1 bit; it resets to instruction, so the data side wins the first tie.
- Accept cycle (IDLE, winner chosen):
  - Assert the winner's ready for exactly that cycle: `dm_awready` and `dm_wready` together for DW, `dm_arready` for DR, `im_arready` for IR.
  - Latch address, data and strobe into registers.
  - Update `last_grant`.
  - Go to RD_ADDR (DR/IR) or WR_ADDR (DW).
- RD_ADDR: drive `mem_arvalid=1` with the latched address. On `mem_arready`, go to RD_DATA.
- RD_DATA:
  - `mem_rready` follows the granted requester's `rready`.
  - The granted requester's `rvalid` follows `mem_rvalid`; the other requester's `rvalid` is held at 0.
  - `rdata` and `rresp` are routed combinationally from `mem_*` to both requesters.
  - On the `mem_rvalid & mem_rready` handshake, go to IDLE.
- WR_ADDR:
  - `mem_awvalid` and `mem_wvalid` both assert on entry. Each deasserts independently after its own handshake.
  - Once both handshakes have completed (in either order, or in the same cycle), go to WR_RESP.
- WR_RESP: `dm_bvalid` follows `mem_bvalid`, `mem_bready` follows `dm_bready`, and `bresp` passes through. On handshake, go to IDLE.
- `rresp`/`bresp` values are passed through unmodified. The arbiter does not retry on error.
- A requester that deasserts its valid before being accepted is simply not granted; this is an AXI protocol violation by that requester and is not checked.

## Timing
- Reset (`rstn` low at a clock edge):
  - State goes to IDLE.
  - Every `*valid` and `*ready` output is 0.
  - Latched address/data/strobe registers are 0.
  - `last_grant` is set to instruction.
  - Any in-flight memory transaction is abandoned; the memory must be reset with the same `rstn`.
- Read latency: accept at cycle N, `mem_arvalid` at N+1. With zero-wait memory, `rvalid` reaches the requester at N+2, and the FSM is back in IDLE at N+3.
- Minimum spacing between accepts is 3 cycles for reads and 3 cycles for writes with zero-wait memory.
- Every `mem_*valid` holds steady, with stable payload, until its handshake.
- Back-pressure: requester `rready`/`bready` low stalls in RD_DATA/WR_RESP indefinitely. No timeout.
- A requester that asserts valid while the FSM is busy waits. Its ready stays 0 until a later IDLE grant.

## Structure
- The shared package holds:
  - the `arb_state_e` enum;
  - the `grant_e` enum {GRANT_DM, GRANT_IM};
  - AXI response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
- No sub-module. One FSM plus request registers, in a single file.

## Test plan
- Single IR to address 0x10, memory returns 0xDEADBEEF with zero wait → `im_arready` pulses at cycle 0; `mem_araddr=0x10` at cycle 1; `im_rvalid` with 0xDEADBEEF at cycle 2; `dm_rvalid` stays 0.
- DR, IR and DW all asserted in the same cycle immediately after reset → grant order is DW, then IR, then DR. Each grant is separated by at least 3 cycles.
- DW with the `mem_awready` handshake 2 cycles before `mem_wready` → `mem_awvalid` drops after its handshake while `mem_wvalid` holds; WR_RESP is entered only after both handshakes; `dm_bresp=RESP_OKAY`.
- IR with `im_rready` held low for 5 cycles → `mem_rready=0` and the FSM stays in RD_DATA. A concurrent DR is not granted until the IR completes.
- `rstn` asserted low while in RD_ADDR → the next cycle shows all outputs at 0 and the FSM in IDLE. After `rstn` is released, a new IR is accepted normally.
- `mem_rresp=RESP_SLVERR` on a DR → `dm_rresp=RESP_SLVERR` is forwarded and the FSM returns to IDLE.
